scmp_run_ctrl: RTL and testbench

SCMP_RUN_CTRL -- requirements
Module: scmp_run_ctrl

---
 rtl/scmp_run_ctrl.sv | 120 ++++++++++++
 tb/tb_scmp_run_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/scmp_run_ctrl.sv
// Run/halt/step controller for a CPU: reset hold, prescaled clock enable, single step.
// Optional breakpoint comparator enabled by defining SCMP_RUN_CTRL_BRK_EN.
module scmp_run_ctrl #(
  parameter int DIV_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run_req,
  input  logic        halt_req,
  input  logic        step_req,
  input  logic [3:0]  div_sel,
  input  logic [11:0] cpu_addr,
  input  logic        cpu_fetch,
  input  logic [11:0] brk_addr,
  input  logic        brk_en,
  output logic        cpu_ce,
  output logic        cpu_rst,
  output logic [1:0]  state,
  output logic        brk_hit
);

  typedef enum logic [1:0] {
    ST_RST_HOLD = 2'd0,
    ST_HALT     = 2'd1,
    ST_RUN      = 2'd2,
    ST_STEP     = 2'd3
  } st_t;

  st_t              st;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] reload;
  logic [1:0]       hold;
  logic             first;
  logic             ce_due;
  logic             stop_fetch;
  logic             hit;

  // Handshake: the *_req inputs are single-cycle pulses with no ready; a
  // request is either acted on at the next edge or dropped, never queued.
  assign reload     = (DIV_W'(1) << div_sel) - DIV_W'(1);
  assign ce_due     = ((st == ST_RUN) || (st == ST_STEP)) && (cnt == '0);
  assign stop_fetch = (st == ST_STEP) && ce_due && cpu_fetch && !first;
  assign cpu_ce     = ce_due && !halt_req && !stop_fetch && !hit;
  assign cpu_rst    = (st == ST_RST_HOLD);
  assign state      = st;

`ifdef SCMP_RUN_CTRL_BRK_EN
  logic skip;
  logic brk_q;

  assign hit     = (st == ST_RUN) && ce_due && brk_en && cpu_fetch &&
                   (cpu_addr == brk_addr) && !skip;
  assign brk_hit = brk_q;

  // skip lets the CPU resume from the instruction it stopped on.
  always_ff @(posedge clk) begin
    if (rst) begin
      skip  <= 1'b0;
      brk_q <= 1'b0;
    end else if ((st == ST_HALT) && !halt_req && (step_req || run_req)) begin
      brk_q <= 1'b0;
      skip  <= !step_req;
    end else if (st == ST_RUN) begin
      if (hit) brk_q <= 1'b1;
      if (cpu_ce) skip <= 1'b0;
    end
  end
`else
  logic unused_brk;

  assign hit        = 1'b0;
  assign brk_hit    = 1'b0;
  assign unused_brk = ^{cpu_addr, brk_addr, brk_en};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      st    <= ST_RST_HOLD;
      cnt   <= '0;
      hold  <= 2'd0;
      first <= 1'b0;
    end else begin
      case (st)
        ST_RST_HOLD: begin
          if (hold == 2'd3) st <= ST_HALT;
          else              hold <= hold + 2'd1;
        end
        ST_HALT: begin
          if (halt_req) begin
            st <= ST_HALT;
          end else if (step_req) begin
            st    <= ST_STEP;
            cnt   <= '0;
            first <= 1'b1;
          end else if (run_req) begin
            st  <= ST_RUN;
            cnt <= '0;
          end
        end
        ST_RUN: begin
          if (halt_req || hit) st  <= ST_HALT;
          else if (ce_due)     cnt <= reload;
          else                 cnt <= cnt - DIV_W'(1);
        end
        ST_STEP: begin
          if (halt_req || stop_fetch) begin
            st <= ST_HALT;
          end else if (ce_due) begin
            cnt   <= reload;
            first <= 1'b0;
          end else begin
            cnt <= cnt - DIV_W'(1);
          end
        end
        default: st <= ST_RST_HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_scmp_run_ctrl.sv
// Self-checking bench for scmp_run_ctrl: reset hold, run/halt, step, priority,
// prescale reload, mid-prescale reset and (with SCMP_RUN_CTRL_BRK_EN) breakpoints.
module tb_scmp_run_ctrl;

  localparam int ST_RST_HOLD = 0;
  localparam int ST_HALT     = 1;
  localparam int ST_RUN      = 2;
  localparam int ST_STEP     = 3;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        run_req, halt_req, step_req;
  logic [3:0]  div_sel;
  logic [11:0] cpu_addr, brk_addr;
  logic        cpu_fetch, brk_en;
  logic        cpu_ce, cpu_rst, brk_hit;
  logic [1:0]  state;

  scmp_run_ctrl #(.DIV_W(16)) dut (
    .clk(clk), .rst(rst),
    .run_req(run_req), .halt_req(halt_req), .step_req(step_req),
    .div_sel(div_sel), .cpu_addr(cpu_addr), .cpu_fetch(cpu_fetch),
    .brk_addr(brk_addr), .brk_en(brk_en),
    .cpu_ce(cpu_ce), .cpu_rst(cpu_rst), .state(state), .brk_hit(brk_hit)
  );

  // scoreboard: expected {state, cpu_ce} per cycle
  logic [2:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_exp(input int st, input logic ce);
    exp_q.push_back({st[1:0], ce});
  endtask

  // driver tasks; all drives happen 1 time unit after a rising edge
  task automatic pulse(input int which);
    if (which == 0) run_req = 1'b1; else step_req = 1'b1;
    @(posedge clk); #1;
    run_req  = 1'b0;
    step_req = 1'b0;
  endtask

  task automatic run_cycles(input int n, input string tag);
    logic [2:0] e;
    repeat (n) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        check({tag, "_q_empty"}, 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check(tag, {29'd0, state, cpu_ce}, {29'd0, e});
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic halt_now(input string tag);
    halt_req = 1'b1;
    @(negedge clk);
    check({tag, "_halt_ce"}, 32'(cpu_ce), 32'd0);
    @(posedge clk); #1;
    halt_req = 1'b0;
    @(negedge clk);
    check({tag, "_halt_state"}, 32'(state), ST_HALT);
    check({tag, "_halt_ce_after"}, 32'(cpu_ce), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic release_reset(input string tag);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check({tag, "_hold_cpu_rst"}, 32'(cpu_rst), 32'd1);
      check({tag, "_hold_state"}, 32'(state), ST_RST_HOLD);
    end
    @(negedge clk);
    check({tag, "_halt_state"}, 32'(state), ST_HALT);
    check({tag, "_halt_cpu_rst"}, 32'(cpu_rst), 32'd0);
    check({tag, "_halt_ce"}, 32'(cpu_ce), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    logic fetch_tab [3];
    fetch_tab[0] = 1'b1; fetch_tab[1] = 1'b0; fetch_tab[2] = 1'b1;

    rst = 1'b1; run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0;
    div_sel = 4'd0; cpu_addr = 12'h000; cpu_fetch = 1'b0;
    brk_addr = 12'h000; brk_en = 1'b0;

    // reset held for 3 cycles
    repeat (3) begin
      @(negedge clk);
      check("rst_state", 32'(state), ST_RST_HOLD);
      check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
      check("rst_ce", 32'(cpu_ce), 32'd0);
      check("rst_brk_hit", 32'(brk_hit), 32'd0);
    end
    @(posedge clk); #1;
    release_reset("init");

    // RUN at div_sel=2: pulse on first cycle then every 4th
    div_sel = 4'd2;
    pulse(0);
    for (int i = 0; i < 12; i++) push_exp(ST_RUN, (i % 4) == 0);
    run_cycles(12, "run_div2");
`ifndef SCMP_RUN_CTRL_BRK_EN
    check("brk_hit_tied", 32'(brk_hit), 32'd0);
`endif
    halt_now("run_div2");

    // div_sel=0: enable every cycle
    div_sel = 4'd0;
    pulse(0);
    for (int i = 0; i < 5; i++) push_exp(ST_RUN, 1'b1);
    run_cycles(5, "run_div0");
    halt_now("run_div0");

    // div_sel changed mid-count only applies at the following reload
    div_sel = 4'd1;
    pulse(0);
    push_exp(ST_RUN, 1'b1); push_exp(ST_RUN, 1'b0); push_exp(ST_RUN, 1'b1);
    for (int i = 0; i < 7; i++) push_exp(ST_RUN, 1'b0);
    push_exp(ST_RUN, 1'b1);
    run_cycles(1, "run_divchg");
    div_sel = 4'd3;
    run_cycles(10, "run_divchg");
    halt_now("run_divchg");

    // single step at div_sel=0, fetch on 1st and 3rd enable cycles
    div_sel = 4'd0;
    pulse(1);
    push_exp(ST_STEP, 1'b1); push_exp(ST_STEP, 1'b1); push_exp(ST_STEP, 1'b0);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      cpu_fetch = fetch_tab[i];
      @(negedge clk);
      pulses += int'(cpu_ce);
      #0;
      run_cycles_one: begin end
      // compare via scoreboard in the same cycle
      if (exp_q.size() == 0) check("step_q_empty", 32'd1, 32'd0);
      else check("step", {29'd0, state, cpu_ce}, {29'd0, exp_q.pop_front()});
      @(posedge clk); #1;
    end
    cpu_fetch = 1'b0;
    @(negedge clk);
    check("step_pulses", pulses, 2);
    check("step_end_state", 32'(state), ST_HALT);
    check("step_end_ce", 32'(cpu_ce), 32'd0);
    @(posedge clk); #1;

    // all three requests at once in HALT: halt wins
    run_req = 1'b1; halt_req = 1'b1; step_req = 1'b1;
    @(posedge clk); #1;
    run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0;
    for (int i = 0; i < 4; i++) push_exp(ST_HALT, 1'b0);
    run_cycles(4, "prio");

`ifdef SCMP_RUN_CTRL_BRK_EN
    // breakpoint hit, then resume past it
    brk_en = 1'b1; brk_addr = 12'h010; div_sel = 4'd1;
    cpu_fetch = 1'b1; cpu_addr = 12'h000;
    pulse(0);
    push_exp(ST_RUN, 1'b1); push_exp(ST_RUN, 1'b0);
    run_cycles(2, "brk_pre");
    cpu_addr = 12'h010;
    push_exp(ST_RUN, 1'b0);
    run_cycles(1, "brk_hit_cycle");
    @(negedge clk);
    check("brk_state", 32'(state), ST_HALT);
    check("brk_flag", 32'(brk_hit), 32'd1);
    @(posedge clk); #1;
    pulse(0);
    @(negedge clk);
    check("brk_resume_ce", 32'(cpu_ce), 32'd1);
    check("brk_resume_flag", 32'(brk_hit), 32'd0);
    @(posedge clk); #1;
    cpu_fetch = 1'b0; brk_en = 1'b0;
    halt_now("brk_resume");
`endif

    // reset in the middle of a long prescale count
    div_sel = 4'd15;
    pulse(0);
    push_exp(ST_RUN, 1'b1);
    for (int i = 0; i < 4; i++) push_exp(ST_RUN, 1'b0);
    run_cycles(5, "run_div15");
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst_state", 32'(state), ST_RST_HOLD);
    check("midrst_ce", 32'(cpu_ce), 32'd0);
    check("midrst_cpu_rst", 32'(cpu_rst), 32'd1);
    @(posedge clk); #1;
    release_reset("midrst");

    check("q_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
